// File: rtl/mux_2x1_comb_pkg.sv
// Shared NoC primitive definitions: command encoding for mux/demux select
// inputs and the dummy-data fill value emitted when a lane is not passed.
package mux_2x1_comb_pkg;

    localparam logic CMD_LOW  = 1'b0;
    localparam logic CMD_HIGH = 1'b1;

    // Fill bit for dummy words; replicate to the lane width at the use site.
    localparam logic DUMMY_BIT = 1'b0;

    function automatic logic dummy_bit();
        return DUMMY_BIT;
    endfunction

endpackage : mux_2x1_comb_pkg

// File: rtl/mux_2x1_comb.sv
// Two-lane valid-qualified data mux used in NoC switch/router trees.
// Combinational by default; OUTPUT_REG=1 adds one registered output stage.
module mux_2x1_comb
    import mux_2x1_comb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int COMMAND_WIDTH = 1,
    parameter bit OUTPUT_REG    = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                i_valid,
    input  logic [2*DATA_WIDTH-1:0]   i_data_bus,
    input  logic                      i_en,
    input  logic [COMMAND_WIDTH-1:0]  i_cmd,
    output logic                      o_valid,
    output logic [DATA_WIDTH-1:0]     o_data_bus
);

    localparam logic [DATA_WIDTH-1:0] DUMMY_DATA = {DATA_WIDTH{DUMMY_BIT}};

    logic                  sel_high;
    logic                  nxt_valid;
    logic [DATA_WIDTH-1:0] nxt_data;
    logic                  unused_cmd_bits;

    assign sel_high = (i_cmd[0] == CMD_HIGH);

    // Only bit 0 of the command selects; wider commands share the encoding
    // with other primitives and their upper bits are deliberately dropped.
    assign unused_cmd_bits = ^i_cmd;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        nxt_valid = 1'b0;
        nxt_data  = DUMMY_DATA;
        if (i_en && i_valid[i_cmd[0]]) begin
            nxt_valid = 1'b1;
            nxt_data  = sel_high ? i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : i_data_bus[DATA_WIDTH-1:0];
        end
    end

    generate
        if (OUTPUT_REG) begin : g_out_reg
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_valid    <= 1'b0;
                    o_data_bus <= DUMMY_DATA;
                end else begin
                    o_valid    <= nxt_valid;
                    o_data_bus <= nxt_data;
                end
            end
        end else begin : g_out_comb
            logic unused_clk;
            assign unused_clk = clk;

            // Reset still forces a clean zero word on the unregistered path.
            assign o_valid    = rst_n ? nxt_valid : 1'b0;
            assign o_data_bus = rst_n ? nxt_data  : DUMMY_DATA;
        end
    endgenerate

endmodule : mux_2x1_comb

// File: tb/tb_mux_2x1_comb.sv
// Directed bench for mux_2x1_comb: one combinational and one registered
// instance share the same stimulus and are checked against fixed vectors.
module tb_mux_2x1_comb;

    logic        clk;
    logic        rst_n;
    logic [1:0]  i_valid;
    logic [63:0] i_data_bus;
    logic        i_en;
    logic [0:0]  i_cmd;

    logic        c_valid;
    logic [31:0] c_data;
    logic        r_valid;
    logic [31:0] r_data;

    int n_compared = 0;
    int n_mismatch = 0;

    localparam logic [63:0] DEF_BUS = {32'hFFFF_FFFF, 32'hAAAA_AAAA};

    mux_2x1_comb #(.DATA_WIDTH(32), .COMMAND_WIDTH(1), .OUTPUT_REG(1'b0)) u_comb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .i_en       (i_en),
        .i_cmd      (i_cmd),
        .o_valid    (c_valid),
        .o_data_bus (c_data)
    );

    mux_2x1_comb #(.DATA_WIDTH(32), .COMMAND_WIDTH(1), .OUTPUT_REG(1'b1)) u_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .i_en       (i_en),
        .i_cmd      (i_cmd),
        .o_valid    (r_valid),
        .o_data_bus (r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatch++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] vld, input logic cmd,
                         input logic [63:0] bus);
        i_en       = en;
        i_valid    = vld;
        i_cmd      = cmd;
        i_data_bus = bus;
    endtask

    // Drive one vector, check the comb instance at once and the registered
    // instance one rising edge later.
    task automatic step(input string tag, input logic en, input logic [1:0] vld,
                        input logic cmd, input logic [63:0] bus,
                        input logic exp_v, input logic [31:0] exp_d);
        drive(en, vld, cmd, bus);
        #1;
        check({tag, "/comb_valid"}, {31'd0, c_valid}, {31'd0, exp_v});
        check({tag, "/comb_data"},  c_data, exp_d);
        @(posedge clk);
        #1;
        check({tag, "/reg_valid"},  {31'd0, r_valid}, {31'd0, exp_v});
        check({tag, "/reg_data"},   r_data, exp_d);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 64'd0);
        #2;
        check("reset/comb_valid", {31'd0, c_valid}, 32'd0);
        check("reset/comb_data",  c_data, 32'd0);
        check("reset/reg_valid",  {31'd0, r_valid}, 32'd0);
        check("reset/reg_data",   r_data, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        step("disabled",    1'b0, 2'b11, 1'b1, DEF_BUS, 1'b0, 32'h0);
        step("sel_high",    1'b1, 2'b10, 1'b1, DEF_BUS, 1'b1, 32'hFFFF_FFFF);
        step("sel_low",     1'b1, 2'b01, 1'b0, DEF_BUS, 1'b1, 32'hAAAA_AAAA);
        step("inv_high",    1'b1, 2'b01, 1'b1, DEF_BUS, 1'b0, 32'h0);
        step("inv_low",     1'b1, 2'b10, 1'b0, DEF_BUS, 1'b0, 32'h0);
        step("disabled_lo", 1'b0, 2'b01, 1'b0, DEF_BUS, 1'b0, 32'h0);

        // Registered output holds the previous word until the next edge.
        drive(1'b1, 2'b01, 1'b0, {32'h0, 32'hFFFF_FFFF});
        #1;
        check("data_chg/comb_data", c_data, 32'hFFFF_FFFF);
        check("data_chg/reg_hold",  {31'd0, r_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("data_chg/reg_data",  r_data, 32'hFFFF_FFFF);
        check("data_chg/reg_valid", {31'd0, r_valid}, 32'd1);

        // Mid-stream reset with select-high active.
        step("pre_rst", 1'b1, 2'b10, 1'b1, DEF_BUS, 1'b1, 32'hFFFF_FFFF);
        rst_n = 1'b0;
        #1;
        check("rst_async/comb_valid", {31'd0, c_valid}, 32'd0);
        check("rst_async/comb_data",  c_data, 32'd0);
        check("rst_async/reg_valid",  {31'd0, r_valid}, 32'd0);
        check("rst_async/reg_data",   r_data, 32'd0);
        @(posedge clk);
        #1;
        check("rst_held/reg_data", r_data, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_rel/comb_data", c_data, 32'hFFFF_FFFF);
        check("rst_rel/reg_wait",  r_data, 32'd0);
        @(posedge clk);
        #1;
        check("rst_rel/reg_valid", {31'd0, r_valid}, 32'd1);
        check("rst_rel/reg_data",  r_data, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule : tb_mux_2x1_comb

// File: doc/mux_2x1_comb.md
Name: mux_2x1_comb

Overview:
- Two-input, one-output data multiplexer with per-input valid qualification. Used as the basic selection element inside NoC switch and router trees.
- Selects the high or low half of a packed input bus under a 1-bit command.
- Outputs a zero dummy word whenever the selection is disabled or the selected input is invalid.
- Combinational by default. An optional output register stage uses the single clock and reset.

Parameters:
- DATA_WIDTH, 32: width of each data lane and of the output.
- COMMAND_WIDTH, 1: width of i_cmd. Only bit 0 is used; upper bits are ignored.
- OUTPUT_REG, 0: 0 = purely combinational path; 1 = one register stage on o_valid and o_data_bus.

Ports:
- clk  input  1  system clock; used only when OUTPUT_REG=1.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  2  bit1 = high lane valid, bit0 = low lane valid.
- i_data_bus  input  2*DATA_WIDTH  high lane in [2*DATA_WIDTH-1:DATA_WIDTH], low lane in [DATA_WIDTH-1:0].
- i_en  input  1  mux enable.
- i_cmd  input  COMMAND_WIDTH  bit0: 1 = select high lane, 0 = select low lane.
- o_valid  output  1  output data valid.
- o_data_bus  output  DATA_WIDTH  selected data, or all zeros.

Behaviour:
- Selection:
  - sel_valid = i_valid[i_cmd[0]].
  - sel_data = i_cmd[0] ? high lane : low lane.
- Combinational result:
  - nxt_valid = i_en & sel_valid.
  - nxt_data = nxt_valid ? sel_data : {DATA_WIDTH{1'b0}}.
- Data passes through unmodified; there is no format change or width conversion.
- Dummy data is {DATA_WIDTH{1'b0}} in every non-valid case:
  - i_en=0, regardless of i_valid and i_cmd;
  - i_en=1 and the selected lane is invalid. The other lane's valid bit and data are ignored.
- OUTPUT_REG=0:
  - o_valid = nxt_valid and o_data_bus = nxt_data, with zero latency.
  - No state is held and clk is unused.
  - While rst_n=0, o_valid=0 and o_data_bus=0, forced combinationally.
- OUTPUT_REG=1:
  - o_valid and o_data_bus register nxt_valid and nxt_data on the rising edge of clk, giving 1-cycle latency.
  - Asserting rst_n low clears both outputs to 0 immediately (asynchronously).
  - On release of rst_n, the first capture happens at the next rising edge.
  - Reset asserted mid-stream discards the in-flight word.
- Reset value of every output is 0 in both modes.
- No handshake or backpressure. The block is a pure select; upstream logic owns flow control.
- Inputs with X or Z are out of contract. The bench must drive all inputs to known values.

Decomposition:
- Shared NoC package holds:
  - the dummy-data constant (all zeros, parameterised by DATA_WIDTH via a function or localparam);
  - the command encoding constants CMD_LOW=0 and CMD_HIGH=1, shared with the other mux/demux primitives.
- No sub-module. The selection is a single always_comb block plus an optional generate-guarded register stage.

Test Plan:
(DATA_WIDTH=32, i_data_bus = {32'hFFFF_FFFF, 32'hAAAA_AAAA} unless stated. Run each scenario for OUTPUT_REG=0 and for OUTPUT_REG=1; with OUTPUT_REG=1, check one clk edge later.)
- Disabled: i_en=0, i_valid=2'b11, i_cmd=1 -> o_valid=0, o_data_bus=32'h0.
- Select high: i_en=1, i_valid=2'b10, i_cmd=1 -> o_valid=1, o_data_bus=32'hFFFF_FFFF.
- Select low: i_en=1, i_valid=2'b01, i_cmd=0 -> o_valid=1, o_data_bus=32'hAAAA_AAAA.
- Selected lane invalid:
  - i_en=1, i_valid=2'b01, i_cmd=1 -> o_valid=0, o_data_bus=32'h0;
  - i_en=1, i_valid=2'b10, i_cmd=0 -> o_valid=0, o_data_bus=32'h0.
- Data change: i_en=1, i_valid=2'b01, i_cmd=0, i_data_bus={32'h0, 32'hFFFF_FFFF} -> o_valid=1, o_data_bus=32'hFFFF_FFFF. Combinational mode updates with no clock edge.
- Reset: assert rst_n=0 while the select-high case is active -> o_valid=0 and o_data_bus=0 immediately. Release -> select-high output returns (after one edge when OUTPUT_REG=1).
